// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder and the cache controller.
// Holds the responder state encoding, the operation type latched on accept,
// the block geometry and the word-address field positions
// (tag [9:7], index [6:2], offset [1:0]).
package mem_pkg;

  localparam int BLOCK_WORDS = 4;
  localparam int OFFSET_W    = 2;
  localparam int CNT_W       = 4;  // holds LATENCY-1 for LATENCY up to 15

  // Word-address field slice positions.
  localparam int TAG_MSB    = 9;
  localparam int TAG_LSB    = 7;
  localparam int INDEX_MSB  = 6;
  localparam int INDEX_LSB  = 2;
  localparam int OFFSET_MSB = 1;
  localparam int OFFSET_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    BURST,
    W_ACK,
    RELEASE
  } mem_state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM backing the responder.
//   clk   : clock, rising edge
//   rst   : synchronous active-low reset, clears only the read-data register
//   en    : access enable
//   we    : write enable (with en); a write does not update rdata
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, holds its value when no read is issued
module mem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset, so its contents survive a reset and
  // it can map onto a plain RAM macro; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Main-memory responder for the data-cache controller.
// Accepts level-sensitive block-refill reads and write-through word writes,
// waits LATENCY cycles, then either streams a 4-word refill burst (offsets
// 0..3) or commits the write, pulses ready_signal_memory, and waits in
// RELEASE until both enables are low so a held request is served only once.
//   clk                 : clock, rising edge
//   rst                 : synchronous active-low reset
//   read_en_memory      : block refill request (wins over a write)
//   write_en_memory     : single-word write-through request
//   address             : word address, latched on accept
//   Data_in             : write data, latched on accept
//   ready_signal_memory : one-cycle completion pulse
//   refill_data         : burst word (holds last value between beats)
//   refill_valid        : refill_data / refill_offset valid this cycle
//   refill_offset       : word offset of the current beat, 0 otherwise
//   busy                : request in progress or awaiting release
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_en_memory,
  input  logic                write_en_memory,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   Data_in,
  output logic                ready_signal_memory,
  output logic [DATA_W-1:0]   refill_data,
  output logic                refill_valid,
  output logic [OFFSET_W-1:0] refill_offset,
  output logic                busy
);

  localparam logic [CNT_W-1:0]    LAT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(BLOCK_WORDS - 1);

  mem_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  mem_op_e             op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                ready_d, valid_d, busy_d;
  logic [OFFSET_W-1:0] offset_d;
  logic                ready_q, valid_q, busy_q;
  logic [OFFSET_W-1:0] offset_q;

  logic                ram_en, ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [ADDR_W-OFFSET_W-1:0] blk_addr;

  assign blk_addr = addr_q[ADDR_W-1:OFFSET_W];

  // Next-state, request latches and RAM control. The RAM read register is the
  // refill_data output, so each word is fetched one cycle ahead of its beat:
  // word 0 in the last WAIT cycle, word k+1 during beat k.
  // NOTE: every signal gets its default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = {blk_addr, {OFFSET_W{1'b0}}};

    unique case (state_q)
      IDLE: begin
        if (read_en_memory || write_en_memory) begin
          state_d = WAIT;
          cnt_d   = LAT_LOAD;
          op_d    = read_en_memory ? OP_READ : OP_WRITE;
          addr_d  = address;
          data_d  = Data_in;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          beat_d = '0;
          if (op_q == OP_READ) begin
            state_d = BURST;
            ram_en  = 1'b1;
          end else begin
            state_d = W_ACK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BURST: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = RELEASE;
        end else begin
          ram_en   = 1'b1;
          ram_addr = {blk_addr, beat_q + 1'b1};
        end
      end
      W_ACK: begin
        // Full latched word address, not the block-aligned one.
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = addr_q;
        state_d  = RELEASE;
      end
      RELEASE: begin
        if (!read_en_memory && !write_en_memory) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    valid_d  = (state_d == BURST);
    offset_d = valid_d ? beat_d : '0;
    ready_d  = (state_d == W_ACK) || ((state_d == BURST) && (beat_d == LAST_BEAT));
    busy_d   = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      beat_q   <= '0;
      op_q     <= OP_READ;
      addr_q   <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      offset_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      offset_q <= offset_d;
      busy_q   <= busy_d;
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem_array (
    .clk  (clk),
    .rst  (rst),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(data_q),
    .rdata(refill_data)
  );

  assign ready_signal_memory = ready_q;
  assign refill_valid        = valid_q;
  assign refill_offset       = offset_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench: two responders (LATENCY 4 and LATENCY 1) share one
// request stream. A driver issues requests and pushes the expected beats and
// ready pulses into per-instance queues from a word-array reference model; a
// monitor compares outputs and the expected busy window every cycle.
module tb_data_memory_responder;

  typedef struct {
    int          cyc;
    bit          ready;
    bit          valid;
    logic [1:0]  off;
    logic [31:0] data;
    bit          known;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren, wen;
  logic [9:0]  addr;
  logic [31:0] din;

  logic        rdy   [2];
  logic        vld   [2];
  logic        bsy   [2];
  logic [31:0] rdata [2];
  logic [1:0]  roff  [2];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  exp_t        sb [2][$];
  bit          act [2];
  int          acc [2];
  int          done [2];
  logic [31:0] last_data [2];
  bit          mon_en = 1'b0;

  logic [31:0] mdl_mem   [1024];
  bit          mdl_known [1024];

  data_memory_responder #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .read_en_memory(ren), .write_en_memory(wen),
    .address(addr), .Data_in(din), .ready_signal_memory(rdy[0]),
    .refill_data(rdata[0]), .refill_valid(vld[0]), .refill_offset(roff[0]),
    .busy(bsy[0])
  );

  data_memory_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .read_en_memory(ren), .write_en_memory(wen),
    .address(addr), .Data_in(din), .ready_signal_memory(rdy[1]),
    .refill_data(rdata[1]), .refill_valid(vld[1]), .refill_offset(roff[1]),
    .busy(bsy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic check(input bit ok, input string name,
                       input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: compares every cycle once the first reset is released.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   eb;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        eb = act[d] && (cyc > acc[d]);
        if (act[d] && (cyc > done[d]) && !ren && !wen) act[d] = 1'b0;
        check(bsy[d] === eb, $sformatf("busy[%0d]@%0d", d, cyc), 32'(bsy[d]), 32'(eb));
        if (sb[d].size() > 0 && sb[d][0].cyc == cyc) begin
          e = sb[d].pop_front();
          check(rdy[d] === e.ready, $sformatf("ready[%0d]@%0d", d, cyc), 32'(rdy[d]), 32'(e.ready));
          check(vld[d] === e.valid, $sformatf("valid[%0d]@%0d", d, cyc), 32'(vld[d]), 32'(e.valid));
          if (e.valid) begin
            check(roff[d] === e.off, $sformatf("offset[%0d]@%0d", d, cyc), 32'(roff[d]), 32'(e.off));
            if (e.known) begin
              check(rdata[d] === e.data, $sformatf("data[%0d]@%0d", d, cyc), rdata[d], e.data);
              last_data[d] = e.data;
            end else begin
              last_data[d] = rdata[d];
            end
          end
        end else begin
          check(!rdy[d] && !vld[d], $sformatf("spurious[%0d]@%0d", d, cyc),
                {30'b0, rdy[d], vld[d]}, 32'h0);
        end
        if (!vld[d]) begin
          check(roff[d] === 2'd0, $sformatf("idle_offset[%0d]@%0d", d, cyc), 32'(roff[d]), 32'h0);
          check(rdata[d] === last_data[d], $sformatf("hold_data[%0d]@%0d", d, cyc),
                rdata[d], last_data[d]);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((act[0] || act[1]) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (act[0] || act[1]) begin
      check(1'b0, "idle_timeout", {30'b0, act[0], act[1]}, 32'h0);
      for (int d = 0; d < 2; d++) begin
        act[d] = 1'b0;
        sb[d].delete();
      end
    end
  endtask

  // Issue one request at the next idle cycle. hold=0 drops the enables after
  // the accept cycle; hold>0 keeps them high that many cycles past the
  // LATENCY-4 instance's ready, scrambling address/data meanwhile.
  task automatic do_req(input bit r, input bit w, input logic [9:0] a,
                        input logic [31:0] dt, input int hold);
    exp_t e;
    int   t0;
    int   b;
    wait_idle();
    ren = r; wen = w; addr = a; din = dt;
    t0 = cyc;
    b  = int'({a[9:2], 2'b00});
    for (int d = 0; d < 2; d++) begin
      act[d]  = 1'b1;
      acc[d]  = t0;
      done[d] = t0 + lat(d) + (r ? 4 : 1);
      if (r) begin
        for (int k = 0; k < 4; k++) begin
          e.cyc   = t0 + lat(d) + 1 + k;
          e.ready = (k == 3);
          e.valid = 1'b1;
          e.off   = 2'(k);
          e.data  = mdl_mem[b + k];
          e.known = mdl_known[b + k];
          sb[d].push_back(e);
        end
      end else begin
        e.cyc = t0 + lat(d) + 1; e.ready = 1'b1; e.valid = 1'b0;
        e.off = 2'd0; e.data = 32'h0; e.known = 1'b0;
        sb[d].push_back(e);
      end
    end
    if (!r) begin
      mdl_mem[a]   = dt;
      mdl_known[a] = 1'b1;
    end
    do begin
      @(posedge clk); #1;
      addr = 10'($urandom);
      din  = $urandom;
    end while (hold > 0 && cyc <= done[0] + hold);
    ren = 1'b0; wen = 1'b0;
  endtask

  // Write whose WAIT phase is cut by reset: nothing must be committed.
  task automatic reset_mid_write(input logic [9:0] a, input logic [31:0] dt);
    wait_idle();
    wen = 1'b1; addr = a; din = dt;
    for (int d = 0; d < 2; d++) begin
      act[d]  = 1'b1;
      acc[d]  = cyc;
      done[d] = cyc + lat(d) + 1;
    end
    @(posedge clk); #1;
    wen = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0;
      sb[d].delete();
      last_data[d] = 32'h0;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int         k;
    int         hold;
    bit         r, w;
    logic [9:0] a;
    rst = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; din = '0;
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; last_data[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    do_req(1'b0, 1'b1, 10'h0A5, 32'hDEADBEEF, 0);
    do_req(1'b0, 1'b1, 10'h100, 32'h11, 0);
    do_req(1'b0, 1'b1, 10'h101, 32'h22, 0);
    do_req(1'b0, 1'b1, 10'h102, 32'h33, 0);
    do_req(1'b0, 1'b1, 10'h103, 32'h44, 0);
    do_req(1'b1, 1'b0, 10'h102, 32'h0, 0);
    do_req(1'b1, 1'b0, 10'h0A4, 32'h0, 0);

    do_req(1'b0, 1'b1, 10'h040, 32'h12345678, 0);
    do_req(1'b1, 1'b1, 10'h040, 32'hBAD0BAD0, 0);
    do_req(1'b1, 1'b0, 10'h040, 32'h0, 0);

    do_req(1'b1, 1'b0, 10'h100, 32'h0, 3);
    do_req(1'b0, 1'b1, 10'h101, 32'h55, 3);

    do_req(1'b0, 1'b1, 10'h010, 32'hAAAA5555, 0);
    reset_mid_write(10'h010, 32'h0BADF00D);
    do_req(1'b1, 1'b0, 10'h010, 32'h0, 0);

    for (int i = 0; i < 32; i++) begin
      do_req(1'b0, 1'b1, 10'h300 + 10'(i), $urandom, 0);
    end
    for (int i = 0; i < 60; i++) begin
      k    = $urandom_range(0, 9);
      a    = 10'h300 + 10'($urandom_range(0, 31));
      r    = (k < 4) || (k == 9);
      w    = (k >= 4);
      hold = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
      do_req(r, w, a, $urandom, hold);
    end

    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check(sb[d].size() == 0, $sformatf("drain[%0d]", d), 32'(sb[d].size()), 32'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
